// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared definitions for the memory-mapped UART.
//   mem_access_t  - CPU data-bus access codes (idle, byte/half/word read/write)
//   UART_REG_*    - register offsets within the 16-byte window
//   ST_*          - STATUS register bit positions
//   tx_state_t / rx_state_t - shifter state machines
package uart_mmio_pkg;

  typedef enum logic [2:0] {
    MEM_NONE    = 3'd0,
    MEM_READ_B  = 3'd1,
    MEM_READ_H  = 3'd2,
    MEM_READ_W  = 3'd3,
    MEM_WRITE_B = 3'd4,
    MEM_WRITE_H = 3'd5,
    MEM_WRITE_W = 3'd6
  } mem_access_t;

  localparam logic [3:0] UART_REG_DATA   = 4'h0;
  localparam logic [3:0] UART_REG_STATUS = 4'h4;
  localparam logic [3:0] UART_REG_DIV    = 4'h8;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_IDLE    = 1;
  localparam int unsigned ST_RX_VALID   = 2;
  localparam int unsigned ST_RX_OVERRUN = 3;
  localparam int unsigned ST_FRAME_ERR  = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic is_read(input mem_access_t a);
    return (a == MEM_READ_B) || (a == MEM_READ_H) || (a == MEM_READ_W);
  endfunction

  function automatic logic is_write(input mem_access_t a);
    return (a == MEM_WRITE_B) || (a == MEM_WRITE_H) || (a == MEM_WRITE_W);
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU data-bus signals between the master and the UART slave.
//   db_addr, db_accessType, db_dataOut : master -> slave
//   db_dataIn, db_ready                : slave -> master (registered, 1-cycle ack)
interface uart_mmio_if;
  import uart_mmio_pkg::*;

  logic [31:0] db_addr;
  mem_access_t db_accessType;
  logic [31:0] db_dataOut;
  logic [31:0] db_dataIn;
  logic        db_ready;

  modport master (
    output db_addr, db_accessType, db_dataOut,
    input  db_dataIn, db_ready
  );

  modport slave (
    input  db_addr, db_accessType, db_dataOut,
    output db_dataIn, db_ready
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: 8-bit synchronous show-ahead FIFO.
//   clk, res_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write when not full (ignored when full)
//   pop        : advance when not empty; rdata shows the head entry
//   full/empty : occupancy flags
module uart_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART slave on the CPU data bus.
//   clk, res_n : clock, async active-low reset
//   db         : data-bus slave (DATA @0x0, STATUS @0x4, DIV @0x8, 0xC reads 0)
//   rx         : serial input (asynchronous, synchronised internally)
//   tx         : serial output, idles high
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       res_n,
  uart_mmio_if.slave db,
  input  logic       rx,
  output logic       tx
);

  // ---------------- bus decode ----------------
  logic        ready_q;
  logic [31:0] data_q;
  logic        sel, access, rd, wr;
  logic [3:0]  offset;
  logic [15:0] div_wr;
  logic [15:0] div_reg;
  logic [31:0] rd_val;
  logic [31:0] status_word;
  logic        overrun_q, frame_q;
  logic        unused_hi;

  assign sel    = (db.db_addr[31:4] == BASE_ADDR[31:4]);
  // The ack cycle never starts a new access.
  assign access = sel && (db.db_accessType != MEM_NONE) && !ready_q;
  assign rd     = access && is_read(db.db_accessType);
  assign wr     = access && is_write(db.db_accessType);
  assign offset = db.db_addr[3:0];

  assign db.db_ready  = ready_q;
  assign db.db_dataIn = data_q;
  assign unused_hi    = ^db.db_dataOut[31:16];

  always_comb begin
    case (db.db_accessType)
      MEM_WRITE_B: div_wr = {8'h00, db.db_dataOut[7:0]};
      default:     div_wr = db.db_dataOut[15:0];
    endcase
  end

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_rdata;
  logic [7:0] rx_shreg;

  tx_state_t  tx_state;
  rx_state_t  rx_state;

  assign tx_push = wr && (offset == UART_REG_DATA) && !tx_full;
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;
  assign rx_pop  = rd && (offset == UART_REG_DATA) && !rx_empty;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (tx_push),
    .wdata (db.db_dataOut[7:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (rx_push),
    .wdata (rx_shreg),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // ---------------- register read mux ----------------
  always_comb begin
    status_word                = '0;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_IDLE]    = tx_empty && (tx_state == TX_IDLE);
    status_word[ST_RX_VALID]   = !rx_empty;
    status_word[ST_RX_OVERRUN] = overrun_q;
    status_word[ST_FRAME_ERR]  = frame_q;
  end

  always_comb begin
    case (offset)
      UART_REG_DATA:   rd_val = rx_empty ? '0 : {24'h0, rx_rdata};
      UART_REG_STATUS: rd_val = status_word;
      UART_REG_DIV:    rd_val = {16'h0, div_reg};
      default:         rd_val = '0;
    endcase
  end

  // ---------------- RX event decode ----------------
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic        rx_stop_smp, overrun_set, frame_set, status_rd;

  assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_push     = rx_stop_smp && rx_s2 && !rx_full;
  assign overrun_set = rx_stop_smp && rx_s2 && rx_full;
  assign frame_set   = rx_stop_smp && !rx_s2;
  assign status_rd   = rd && (offset == UART_REG_STATUS);

  // ---------------- bus registers ----------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ready_q   <= 1'b0;
      data_q    <= '0;
      div_reg   <= DEFAULT_DIV;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      ready_q <= access;
      data_q  <= rd ? rd_val : '0;
      if (wr && (offset == UART_REG_DIV))
        div_reg <= (div_wr < 16'd2) ? 16'd2 : div_wr;
      // A new error wins over the clear of a coincident STATUS read.
      if (overrun_set)    overrun_q <= 1'b1;
      else if (status_rd) overrun_q <= 1'b0;
      if (frame_set)      frame_q   <= 1'b1;
      else if (status_rd) frame_q   <= 1'b0;
    end
  end

  // ---------------- TX shifter ----------------
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shreg;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx       <= 1'b1;
    end else begin
      // tx is a registered copy of the current bit, one cycle behind the state.
      case (tx_state)
        TX_START: tx <= 1'b0;
        TX_DATA:  tx <= tx_shreg[0];
        default:  tx <= 1'b1;
      endcase
      if (tx_state == TX_IDLE) begin
        if (!tx_empty) begin
          tx_shreg <= tx_rdata;
          tx_cnt   <= div_reg - 16'd1;
          tx_state <= TX_START;
        end
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        // Bit boundary: the latest divider is picked up here.
        tx_cnt <= div_reg - 16'd1;
        case (tx_state)
          TX_START: begin
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_idx   <= tx_idx + 3'd1;
            if (tx_idx == 3'd7) tx_state <= TX_STOP;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX shifter ----------------
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_state == RX_IDLE) begin
        // Falling edge of the synchronised line; first sample half a bit later.
        if (rx_s3 && !rx_s2) begin
          rx_cnt   <= (div_reg >> 1) - 16'd1;
          rx_state <= RX_START;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= div_reg - 16'd1;
        case (rx_state)
          RX_START: begin
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
          RX_DATA: begin
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  int   errors = 0;
  int   checks = 0;

  uart_mmio_if bus ();

  uart_mmio #(
    .BASE_ADDR   (BASE),
    .DEFAULT_DIV (16'd434),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .db    (bus),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus access; lat = cycles until db_ready (0 if none within 8).
  task automatic bus_access(input logic [31:0] addr, input mem_access_t kind,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int lat);
    @(negedge clk);
    if (bus.db_ready) @(negedge clk);
    bus.db_addr       = addr;
    bus.db_accessType = kind;
    bus.db_dataOut    = wdata;
    lat   = 0;
    rdata = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.db_ready) begin
        lat   = i;
        rdata = bus.db_dataIn;
        break;
      end
    end
    bus.db_accessType = MEM_NONE;
  endtask

  task automatic reg_write(input string tag, input logic [3:0] off, input mem_access_t kind,
                           input logic [31:0] wdata);
    logic [31:0] d;
    int lat;
    bus_access(BASE + {28'h0, off}, kind, wdata, d, lat);
    check({tag, "_ack"}, lat, 1);
  endtask

  task automatic reg_read(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    bus_access(BASE + {28'h0, off}, MEM_READ_W, '0, d, lat);
    check({tag, "_ack"}, lat, 1);
    check(tag, d, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
    @(negedge clk);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop;
    repeat (div) @(negedge clk);
    rx = 1'b1;
  endtask

  // Decode one frame from tx by mid-bit sampling; ok=0 on timeout or bad stop.
  task automatic grab_tx(input int div, output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    b  = '0;
    while (tx !== 1'b0 && n < 30 * div) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tx === 1'b0) begin
      repeat (div / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(posedge clk);
        #1;
        b[i] = tx;
      end
      repeat (div) @(posedge clk);
      #1;
      ok = (tx === 1'b1);
    end
  endtask

  initial begin
    logic [7:0]  frame_byte;
    logic [3:0]  smp;
    logic        bit_exp;
    logic [7:0]  got_b;
    logic        ok;
    logic [31:0] d;
    int          lat;

    bus.db_addr       = '0;
    bus.db_accessType = MEM_NONE;
    bus.db_dataOut    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_low", {31'h0, tx}, 32'h1);
    @(negedge clk);
    res_n = 1'b1;
    #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_ready", {31'h0, bus.db_ready}, 32'h0);
    check("rst_dataIn", bus.db_dataIn, 32'h0);
    reg_read("rst_status", 4'h4, 32'h2);
    reg_read("rst_div", 4'h8, 32'd434);

    // Divider clamp, byte-write width, unused offset
    reg_write("div1", 4'h8, MEM_WRITE_W, 32'h1);
    reg_read("div_clamp", 4'h8, 32'h2);
    reg_write("div_b", 4'h8, MEM_WRITE_B, 32'hABCD_0107);
    reg_read("div_byte", 4'h8, 32'h7);
    reg_write("offc", 4'hC, MEM_WRITE_W, 32'hDEAD_BEEF);
    reg_read("offc_rd", 4'hC, 32'h0);

    // TX frame 0x55 at DIV=4
    reg_write("div4", 4'h8, MEM_WRITE_W, 32'h4);
    frame_byte = 8'h55;
    reg_write("tx55", 4'h0, MEM_WRITE_W, {24'h0, frame_byte});
    @(posedge clk);
    #1;
    check("tx_pre_start", {31'h0, tx}, 32'h1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        smp[j] = tx;
        @(posedge clk);
        #1;
      end
      if (k == 0)      bit_exp = 1'b0;
      else if (k == 9) bit_exp = 1'b1;
      else             bit_exp = frame_byte[k-1];
      check($sformatf("tx_bit%0d", k), {28'h0, smp}, {28'h0, {4{bit_exp}}});
    end
    reg_read("tx_done_status", 4'h4, 32'h2);

    // RX 0xA3
    send_byte(8'hA3, 1'b1, 4);
    repeat (8) @(negedge clk);
    reg_read("rx_status", 4'h4, 32'h6);
    reg_read("rx_data", 4'h0, 32'hA3);
    reg_read("rx_status2", 4'h4, 32'h2);
    reg_read("rx_empty_data", 4'h0, 32'h0);

    // Overrun: five bytes, no reads
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h10 * i + i), 1'b1, 4);
    repeat (8) @(negedge clk);
    reg_read("ovr_status", 4'h4, 32'hE);
    for (int i = 1; i <= 4; i++) reg_read($sformatf("ovr_data%0d", i), 4'h0, 32'(8'h10 * i + i));
    reg_read("ovr_status2", 4'h4, 32'h2);

    // Glitch, then a frame with a bad stop bit
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    reg_read("glitch_status", 4'h4, 32'h2);
    send_byte(8'h5A, 1'b0, 4);
    repeat (8) @(negedge clk);
    reg_read("frame_status", 4'h4, 32'h12);
    reg_read("frame_status2", 4'h4, 32'h2);

    // TX full at DIV=100
    reg_write("div100", 4'h8, MEM_WRITE_W, 32'd100);
    for (int i = 1; i <= 6; i++) reg_write($sformatf("txf_w%0d", i), 4'h0, MEM_WRITE_B, 32'(8'h30 + i));
    reg_read("txf_status", 4'h4, 32'h1);
    for (int i = 1; i <= 5; i++) begin
      grab_tx(100, got_b, ok);
      check($sformatf("txf_ok%0d", i), {31'h0, ok}, 32'h1);
      check($sformatf("txf_byte%0d", i), {24'h0, got_b}, 32'(8'h30 + i));
    end
    grab_tx(100, got_b, ok);
    check("txf_no_sixth", {31'h0, ok}, 32'h0);

    // Unselected address
    bus_access(BASE + 32'h10, MEM_READ_W, '0, d, lat);
    check("decode_no_ready", lat, 0);

    // Reset in the middle of a frame
    reg_write("div4b", 4'h8, MEM_WRITE_W, 32'h4);
    reg_write("tx00", 4'h0, MEM_WRITE_W, 32'h0);
    repeat (10) @(posedge clk);
    #2;
    check("mid_tx_low", {31'h0, tx}, 32'h0);
    res_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'h0, tx}, 32'h1);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    reg_read("post_rst_status", 4'h4, 32'h2);
    reg_read("post_rst_div", 4'h8, 32'd434);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
